// File: rtl/spell_io_pkg.sv
// Shared types and constants for the CPU/debug I/O arbiter.
package spell_io_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  localparam logic       PORT_CPU  = 1'b0;
  localparam logic       PORT_DBG  = 1'b1;
  localparam logic [7:0] ERR_RDATA = 8'hff;

endpackage

// File: rtl/spell_rr_pick2.sv
// Combinational two-way round-robin chooser: on a tie the port that was not
// served last wins.
module spell_rr_pick2
  import spell_io_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid = |eligible;
    if (&eligible) begin
      winner = ~last;
    end else begin
      winner = eligible[PORT_DBG];
    end
  end

endmodule

// File: rtl/spell_io_arbiter.sv
// Serialises CPU and debug accesses onto the single-transaction I/O register
// bus, with a watchdog that aborts accesses whose ready never arrives.
module spell_io_arbiter
  import spell_io_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_write,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  output logic       cpu_err,
  input  logic       dbg_req,
  input  logic [7:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  input  logic       dbg_write,
  output logic       dbg_ack,
  output logic [7:0] dbg_rdata,
  output logic       dbg_err,
  output logic       io_select,
  output logic [7:0] io_addr,
  output logic [7:0] io_wdata,
  output logic       io_write,
  input  logic [7:0] io_rdata,
  input  logic       io_ready,
  output logic       busy,
  output logic       owner
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            io_select_q, io_select_d;
  logic            io_write_q, io_write_d;
  logic [7:0]      io_addr_q, io_addr_d;
  logic [7:0]      io_wdata_q, io_wdata_d;
  logic [1:0]      ack_q, ack_d;
  logic [1:0]      err_q, err_d;
  logic [1:0][7:0] rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic            owner_q, owner_d;

  logic [1:0]      eligible;
  logic            pick_valid;
  logic            pick_winner;

  // A port whose ack is still high may keep req up for that cycle; ignore it.
  assign eligible[PORT_CPU] = cpu_req & ~ack_q[PORT_CPU];
  assign eligible[PORT_DBG] = dbg_req & ~ack_q[PORT_DBG];

  spell_rr_pick2 u_pick (
    .eligible (eligible),
    .last     (owner_q),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    io_select_d = io_select_q;
    io_write_d  = io_write_q;
    io_addr_d   = io_addr_q;
    io_wdata_d  = io_wdata_q;
    ack_d       = '0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    owner_d     = owner_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          if (pick_winner == PORT_DBG) begin
            io_addr_d  = dbg_addr;
            io_wdata_d = dbg_wdata;
            io_write_d = dbg_write;
          end else begin
            io_addr_d  = cpu_addr;
            io_wdata_d = cpu_wdata;
            io_write_d = cpu_write;
          end
          io_select_d = 1'b1;
          owner_d     = pick_winner;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (io_ready) begin
          rdata_d[owner_q] = io_rdata;
          err_d[owner_q]   = 1'b0;
          ack_d[owner_q]   = 1'b1;
          io_select_d      = 1'b0;
          busy_d           = 1'b0;
          state_d          = IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rdata_d[owner_q] = ERR_RDATA;
          err_d[owner_q]   = 1'b1;
          ack_d[owner_q]   = 1'b1;
          io_select_d      = 1'b0;
          busy_d           = 1'b0;
          state_d          = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      io_select_q <= 1'b0;
      io_write_q  <= 1'b0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      owner_q     <= PORT_DBG;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      io_select_q <= io_select_d;
      io_write_q  <= io_write_d;
      io_addr_q   <= io_addr_d;
      io_wdata_q  <= io_wdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
    end
  end

  assign cpu_ack   = ack_q[PORT_CPU];
  assign cpu_rdata = rdata_q[PORT_CPU];
  assign cpu_err   = err_q[PORT_CPU];
  assign dbg_ack   = ack_q[PORT_DBG];
  assign dbg_rdata = rdata_q[PORT_DBG];
  assign dbg_err   = err_q[PORT_DBG];
  assign io_select = io_select_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;
  assign io_write  = io_write_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_spell_io_arbiter.sv
// Self-checking bench for spell_io_arbiter: directed scenarios plus random
// transactions checked against a transaction-level model of the arbiter.
module tb_spell_io_arbiter;

  localparam int unsigned TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_write, cpu_ack, cpu_err;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       dbg_req, dbg_write, dbg_ack, dbg_err;
  logic [7:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic       io_select, io_write, io_ready;
  logic [7:0] io_addr, io_wdata, io_rdata;
  logic       busy, owner;

  always #5 clk = ~clk;

  spell_io_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_write (cpu_write),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_write (dbg_write),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .dbg_err   (dbg_err),
    .io_select (io_select),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_write  (io_write),
    .io_rdata  (io_rdata),
    .io_ready  (io_ready),
    .busy      (busy),
    .owner     (owner)
  );

  // I/O register block: registered ready/data, write on the first select
  // cycle only, address 8'h36 is a toggle register (portb_out).
  logic [7:0] mem [256];
  logic       prev_sel = 1'b0;
  logic       io_hang;
  logic       mem_clr;

  always @(posedge clk) begin
    prev_sel <= io_select;
    io_ready <= io_select & ~io_hang;
    io_rdata <= io_write ? 8'h00 : mem[io_addr];
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (io_select && !prev_sel && io_write) begin
      mem[io_addr] <= (io_addr == 8'h36) ? (mem[io_addr] ^ io_wdata) : io_wdata;
    end
  end

  // Transaction-level reference state
  logic [7:0] exp_mem [256];
  logic       m_owner;
  logic [7:0] m_rd [2];
  logic       m_err [2];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] apply(input logic [7:0] a, input logic [7:0] wd,
                                       input logic wr, input bit hang);
    logic [7:0] rd;
    rd = exp_mem[a];
    if (wr) exp_mem[a] = (a == 8'h36) ? (exp_mem[a] ^ wd) : wd;
    if (hang) return 8'hff;
    return wr ? 8'h00 : rd;
  endfunction

  task automatic xact(input string name, input bit c_en, input bit d_en,
                      input logic [7:0] ca, input logic [7:0] cw, input logic cwr,
                      input logic [7:0] da, input logic [7:0] dw, input logic dwr,
                      input bit hang, input bit hold);
    int         lat, budget, n, rises, hi, gap;
    logic       first, p, prev;
    logic [7:0] o_addr [2];
    logic [7:0] o_wd [2];
    logic       o_wr [2];
    int         exp_cyc [2];
    logic [7:0] exp_rd [2];
    int         ack_cnt [2];
    int         ack_cyc [2];

    lat   = hang ? int'(TIMEOUT) + 2 : 3;
    first = (c_en && d_en) ? ~m_owner : (d_en ? 1'b1 : 1'b0);
    n     = 0;
    exp_cyc = '{-1, -1};
    exp_rd  = '{8'h00, 8'h00};
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? first : ~first;
      if ((!p && c_en) || (p && d_en)) begin
        o_addr[n] = p ? da : ca;
        o_wd[n]   = p ? dw : cw;
        o_wr[n]   = p ? dwr : cwr;
        exp_rd[p] = apply(o_addr[n], o_wd[n], o_wr[n], hang);
        exp_cyc[p] = (n + 1) * lat;
        m_owner   = p;
        n++;
      end
    end

    io_hang   = hang;
    cpu_req   = c_en; cpu_addr = ca; cpu_wdata = cw; cpu_write = cwr;
    dbg_req   = d_en; dbg_addr = da; dbg_wdata = dw; dbg_write = dwr;
    ack_cnt   = '{0, 0};
    ack_cyc   = '{0, 0};
    rises = 0; hi = 0; gap = 0;
    prev   = io_select;
    budget = 2 * lat + 3;

    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clk); #1;
      if (io_select) begin
        if (!prev) begin
          if (rises < n) begin
            chk({name, " io_addr"}, io_addr, o_addr[rises]);
            chk({name, " io_write"}, io_write, o_wr[rises]);
            chk({name, " io_wdata"}, io_wdata, o_wd[rises]);
            chk({name, " busy"}, busy, 1);
          end
          if (rises > 0) chk({name, " select_gap"}, gap, 1);
          rises++;
          gap = 0;
        end
        hi++;
      end else begin
        gap++;
      end
      prev = io_select;
      if (cpu_ack) begin
        ack_cnt[0]++; ack_cyc[0] = cyc;
        chk({name, " cpu_ack_cycle"}, cyc, exp_cyc[0]);
        chk({name, " cpu_rdata"}, cpu_rdata, exp_rd[0]);
        chk({name, " cpu_err"}, cpu_err, hang);
        chk({name, " owner_cpu"}, owner, 0);
        if (c_en) begin m_rd[0] = exp_rd[0]; m_err[0] = hang; end
      end
      if (dbg_ack) begin
        ack_cnt[1]++; ack_cyc[1] = cyc;
        chk({name, " dbg_ack_cycle"}, cyc, exp_cyc[1]);
        chk({name, " dbg_rdata"}, dbg_rdata, exp_rd[1]);
        chk({name, " dbg_err"}, dbg_err, hang);
        chk({name, " owner_dbg"}, owner, 1);
        if (d_en) begin m_rd[1] = exp_rd[1]; m_err[1] = hang; end
      end
      if (cpu_req && ack_cnt[0] > 0 && cyc >= ack_cyc[0] + (hold ? 1 : 0)) cpu_req = 1'b0;
      if (dbg_req && ack_cnt[1] > 0 && cyc >= ack_cyc[1] + (hold ? 1 : 0)) dbg_req = 1'b0;
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;

    chk({name, " cpu_ack_count"}, ack_cnt[0], c_en);
    chk({name, " dbg_ack_count"}, ack_cnt[1], d_en);
    chk({name, " select_rises"}, rises, n);
    chk({name, " select_high_cycles"}, hi, n * (lat - 1));
    chk({name, " cpu_rdata_hold"}, cpu_rdata, m_rd[0]);
    chk({name, " cpu_err_hold"}, cpu_err, m_err[0]);
    chk({name, " dbg_rdata_hold"}, dbg_rdata, m_rd[1]);
    chk({name, " dbg_err_hold"}, dbg_err, m_err[1]);
  endtask

  initial begin
    logic [7:0] orig;
    int         mode;
    bit         r_hang, r_hold;
    logic [7:0] ra [2];

    rst = 1'b1; mem_clr = 1'b1; io_hang = 1'b0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_write = 1'b0;
    dbg_req = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_write = 1'b0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    m_owner = 1'b1;
    m_rd = '{8'h00, 8'h00};
    m_err = '{1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst io_select", io_select, 0);
    chk("rst io_write", io_write, 0);
    chk("rst io_addr", io_addr, 0);
    chk("rst io_wdata", io_wdata, 0);
    chk("rst acks", {cpu_ack, dbg_ack}, 0);
    chk("rst errs", {cpu_err, dbg_err}, 0);
    chk("rst rdata", {cpu_rdata, dbg_rdata}, 0);
    chk("rst busy", busy, 0);
    chk("rst owner", owner, 1);
    rst = 1'b0; mem_clr = 1'b0;

    // Simultaneous requests: cpu first after reset, then rotation
    xact("tie1", 1, 1, 8'h10, 8'h00, 0, 8'h11, 8'h00, 0, 0, 0);
    xact("tie2", 1, 1, 8'h12, 8'h00, 0, 8'h13, 8'h00, 0, 0, 0);

    // Preload 8'h38 then cpu read, dbg outputs must not move
    xact("pre38", 0, 1, 8'h00, 8'h00, 0, 8'h38, 8'h5a, 1, 0, 0);
    xact("rd38", 1, 0, 8'h38, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);

    // Back-to-back toggle-register writes must both land
    orig = exp_mem[8'h36];
    xact("toggle", 1, 1, 8'h36, 8'h01, 1, 8'h36, 8'h01, 1, 0, 0);
    chk("portb_restored", mem[8'h36], orig);

    // Watchdog abort, then normal access
    xact("timeout", 0, 1, 8'h00, 8'h00, 0, 8'h40, 8'h00, 0, 1, 0);
    xact("after_to", 1, 0, 8'h38, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);

    // Requester holding req one cycle past ack
    xact("hold", 1, 0, 8'h38, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1);

    // Reset in the second ACCESS cycle
    io_hang = 1'b0;
    cpu_req = 1'b1; cpu_addr = 8'h38; cpu_write = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid io_select", io_select, 1);
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst io_select", io_select, 0);
    chk("mid_rst cpu_ack", cpu_ack, 0);
    chk("mid_rst owner", owner, 1);
    chk("mid_rst busy", busy, 0);
    m_owner = 1'b1;
    m_rd = '{8'h00, 8'h00};
    m_err = '{1'b0, 1'b0};
    xact("reissue", 1, 0, 8'h38, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);

    // Random mix
    for (int it = 0; it < 40; it++) begin
      mode   = int'($urandom_range(0, 2));
      r_hang = ($urandom_range(0, 7) == 0);
      r_hold = $urandom_range(0, 1) == 1;
      for (int k = 0; k < 2; k++)
        ra[k] = ($urandom_range(0, 3) == 0) ? 8'h36 : 8'($urandom_range(0, 15));
      xact("rand", mode != 1, mode != 0,
           ra[0], 8'($urandom), 1'($urandom),
           ra[1], 8'($urandom), 1'($urandom), r_hang, r_hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spell_io_arbiter.md
# spell_io_arbiter

Two-port arbiter that shares the single-transaction memory-mapped I/O register block between the CPU core's data port and the debug/loader port. It serialises requests with round-robin fairness, drives the I/O block's select/addr/data/write bus, and returns read data and a one-cycle acknowledge to the winning requester. It enforces a minimum one-cycle select-low gap between transactions so the I/O block's first-write-cycle edge detection sees every write. A watchdog aborts accesses whose data_ready never arrives.

## Interface
- TIMEOUT, 15: max cycles in ACCESS waiting for io_ready before abort; ≥2.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  level request; held until cpu_ack
- cpu_addr  in  8  register address; stable while cpu_req
- cpu_wdata  in  8  write data; stable while cpu_req
- cpu_write  in  1  1=write, 0=read; stable while cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid with cpu_ack; holds until next cpu_ack
- cpu_err  out  1  valid with cpu_ack; 1=timed out
- dbg_req, dbg_addr, dbg_wdata, dbg_write, dbg_ack, dbg_rdata, dbg_err: same as cpu_* for the debug port
- io_select  out  1  to I/O block select
- io_addr  out  8  to I/O block addr
- io_wdata  out  8  to I/O block data_in
- io_write  out  1  to I/O block write
- io_rdata  in  8  from I/O block data_out
- io_ready  in  1  from I/O block data_ready
- busy  out  1  1 while in ACCESS
- owner  out  1  port of current/last grant (0=cpu, 1=dbg)

## Operation
- States: IDLE, ACCESS. All outputs registered.
- IDLE: eligible = req of each port, masked by that port's ack currently high (a requester may drop req the cycle after ack). If any eligible: pick winner (see below), latch its addr/wdata/write into io_*, io_select←1, owner←winner, clear timeout counter, go ACCESS. Otherwise stay, io_select=0.
- Round robin: if only one eligible, it wins. If both, the port ≠ owner wins. After reset owner=1, so cpu wins the first tie.
- ACCESS: io_select and io_* held constant. Counter increments each cycle.
  - io_ready=1: <port>_rdata←io_rdata, <port>_err←0, <port>_ack←1, io_select←0, go IDLE.
  - counter reaches TIMEOUT with io_ready=0: <port>_rdata←8'hff, <port>_err←1, ack←1, io_select←0, go IDLE.
- Writes: rdata on ack is whatever io_rdata showed (the I/O block returns 0); requesters ignore it.
- Since io_select falls on leaving ACCESS and IDLE lasts ≥1 cycle, select is low ≥1 cycle between any two transactions, including back-to-back writes to the toggle register by either port.
- io_ready is ignored in IDLE. A stale io_ready=1 in the cycle after select falls cannot complete a later access, because ACCESS is entered only after a select-low cycle.
- Reset: state=IDLE; io_select, io_write, io_addr, io_wdata, both acks, both err, both rdata, busy = 0; owner=1; counter=0. Reset mid-ACCESS drops io_select next edge; the in-flight request gets no ack and must be re-issued.
- A requester dropping req mid-ACCESS is a protocol violation; the transaction still completes and acks.

## Timing
- Request seen in IDLE at edge N → io_select=1 after N. With the I/O block's registered data_ready, io_ready=1 after N+1, ack=1 after N+2 (rdata valid). Three cycles from req sampled to ack for a single access.
- Back-to-back, with the other port waiting: select low for exactly 1 cycle; issue rate is one access per 3 cycles.
- Timeout: ack after TIMEOUT+1 cycles following select rise.
- Counter width = $clog2(TIMEOUT+1).

## Structure
- Package spell_io_pkg: state enum (IDLE, ACCESS), port index localparams PORT_CPU=0 and PORT_DBG=1, ERR_RDATA=8'hff.
- Sub-module spell_rr_pick2: combinational 2-way round-robin chooser (inputs: eligible[1:0], last; outputs: valid, winner).
- Top holds the FSM, latches, watchdog counter and per-port response registers.

## Test plan
- cpu read of addr 8'h38 with I/O block model returning 8'h5a → io_select high 2 cycles, cpu_ack 3 cycles after req, cpu_rdata=8'h5a, cpu_err=0; dbg outputs unchanged.
- cpu and dbg request in the same cycle after reset, both held → cpu granted first, then dbg, then cpu again; io_select low exactly 1 cycle between each.
- Two consecutive writes of 8'h01 to 8'h36 (cpu then dbg) against the real I/O block → portb_out toggles twice, ending at its original value.
- I/O model never asserts ready, TIMEOUT=15 → dbg_ack 16 cycles after select rise, dbg_rdata=8'hff, dbg_err=1; a following cpu read succeeds normally.
- rst asserted in the second ACCESS cycle → next cycle io_select=0, no ack pulse, owner=1; a request re-issued afterwards completes in 3 cycles.
- Requester keeps req high for 1 cycle after ack → no duplicate transaction issued.
